// File: rtl/lc3b_types.sv
// Shared LC-3b types: data word, performance-counter index and counter window base.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    PERF_BPRED    = 2'd0,
    PERF_BMISPRED = 2'd1,
    PERF_STALL    = 2'd2,
    PERF_CYCLE    = 2'd3
  } lc3b_perf_idx;

  typedef enum logic {
    PERF_IDLE = 1'b0,
    PERF_RESP = 1'b1
  } perf_state_e;

  localparam lc3b_word PERF_BASE_DEFAULT = 16'hFFF0;

endpackage

// File: rtl/perf_counter.sv
// One 16-bit event counter: a load beats an increment in the same cycle.
// PERF_SATURATE_EN: stick at 16'hFFFF instead of wrapping to zero.
module perf_counter
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     inc,
  input  logic     load,
  input  lc3b_word load_data,
  output lc3b_word count
);

  // Counter register; a load discards a coincident increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= 16'h0000;
    end else if (load) begin
      count <= load_data;
    end else if (inc) begin
`ifdef PERF_SATURATE_EN
      if (count != 16'hFFFF) begin
        count <= count + 16'h0001;
      end else begin
        count <= count;
      end
`else
      count <= count + 16'h0001;
`endif
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// Memory-mapped bank of four performance counters with a one-cycle response handshake.
// Define PERF_SATURATE_EN to make the counters saturate instead of wrap.
module perf_counter_bank
  import lc3b_types::*;
#(
  parameter lc3b_word BASE_ADDR = PERF_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        bpredicts_inc,
  input  logic        bmispredicts_inc,
  input  logic        stalls_inc,
  input  lc3b_word    mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [15:0] mem_wdata,
  output logic        perf_sel,
  output logic [15:0] perf_rdata,
  output logic        perf_resp
);

  perf_state_e  state_r;
  lc3b_perf_idx idx_s;
  logic         hit_s;
  logic         accept_s;
  logic [3:0]   load_s;
  logic [3:0]   inc_s;
  lc3b_word     count_s [4];
  lc3b_word     rd_mux_s;
  logic         unused_addr_lsb_s;

  assign hit_s             = (mem_address[15:3] == BASE_ADDR[15:3]);
  assign perf_sel          = hit_s & (mem_read | mem_write);
  assign idx_s             = lc3b_perf_idx'(mem_address[2:1]);
  assign accept_s          = (state_r == PERF_IDLE) & perf_sel;
  assign inc_s             = {1'b1, stalls_inc, bmispredicts_inc, bpredicts_inc};
  assign unused_addr_lsb_s = mem_address[0];

  // Write strobe to the addressed counter; read+write together counts as a write
  always_comb begin
    load_s = 4'b0000;
    if (accept_s && mem_write) begin
      load_s[idx_s] = 1'b1;
    end else begin
      load_s = 4'b0000;
    end
  end

  for (genvar i = 0; i < 4; i++) begin : g_ctr
    perf_counter u_ctr (
      .clk       (clk),
      .rst_n     (rst_n),
      .inc       (inc_s[i]),
      .load      (load_s[i]),
      .load_data (mem_wdata),
      .count     (count_s[i])
    );
  end

  // Read mux over pre-increment counter values (snapshot of the accepting cycle)
  always_comb begin
    rd_mux_s = 16'h0000;
    case (idx_s)
      PERF_BPRED:    rd_mux_s = count_s[0];
      PERF_BMISPRED: rd_mux_s = count_s[1];
      PERF_STALL:    rd_mux_s = count_s[2];
      PERF_CYCLE:    rd_mux_s = count_s[3];
      default:       rd_mux_s = 16'h0000;
    endcase
  end

  // Handshake FSM: accept in IDLE, pulse perf_resp for one cycle in RESP
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= PERF_IDLE;
      perf_resp  <= 1'b0;
      perf_rdata <= 16'h0000;
    end else begin
      case (state_r)
        PERF_IDLE: begin
          if (accept_s) begin
            state_r    <= PERF_RESP;
            perf_resp  <= 1'b1;
            perf_rdata <= mem_write ? 16'h0000 : rd_mux_s;
          end else begin
            state_r    <= PERF_IDLE;
            perf_resp  <= 1'b0;
          end
        end
        PERF_RESP: begin
          state_r   <= PERF_IDLE;
          perf_resp <= 1'b0;
        end
        default: begin
          state_r   <= PERF_IDLE;
          perf_resp <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perf_counter_bank.sv
// Scoreboard bench for perf_counter_bank: directed scenarios followed by random traffic.
module tb_perf_counter_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        bpredicts_inc = 1'b0;
  logic        bmispredicts_inc = 1'b0;
  logic        stalls_inc = 1'b0;
  logic [15:0] mem_address = 16'h0000;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [15:0] mem_wdata = 16'h0000;
  logic        perf_sel;
  logic [15:0] perf_rdata;
  logic        perf_resp;

  int checks = 0;
  int failures = 0;

  // reference model state
  int unsigned cnt [4];
  int unsigned exp_q [$];
  bit          m_busy = 1'b0;

  perf_counter_bank dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bpredicts_inc    (bpredicts_inc),
    .bmispredicts_inc (bmispredicts_inc),
    .stalls_inc       (stalls_inc),
    .mem_address      (mem_address),
    .mem_read         (mem_read),
    .mem_write        (mem_write),
    .mem_wdata        (mem_wdata),
    .perf_sel         (perf_sel),
    .perf_rdata       (perf_rdata),
    .perf_resp        (perf_resp)
  );

  always #5 clk = ~clk;

  function automatic bit in_win(logic [15:0] a);
    return (a >= 16'hFFF0) && (a <= 16'hFFF7);
  endfunction

  function automatic int unsigned bump(int unsigned v);
`ifdef PERF_SATURATE_EN
    return (v == 32'd65535) ? 32'd65535 : v + 32'd1;
`else
    return (v + 32'd1) % 32'd65536;
`endif
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: one step per clock from the rules, cleared by reset
  always @(posedge clk or negedge rst_n) begin : model
    int w;
    int idx;
    bit [3:0] ev;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) cnt[i] = 0;
      exp_q.delete();
      m_busy = 1'b0;
    end else begin
      w = -1;
      if (!m_busy && in_win(mem_address) && (mem_read || mem_write)) begin
        idx = int'(mem_address - 16'hFFF0) / 2;
        if (mem_write) begin
          w = idx;
          exp_q.push_back(0);
        end else begin
          exp_q.push_back(cnt[idx]);
        end
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
      ev = {1'b1, stalls_inc, bmispredicts_inc, bpredicts_inc};
      for (int i = 0; i < 4; i++) begin
        if (i == w) cnt[i] = mem_wdata;
        else if (ev[i]) cnt[i] = bump(cnt[i]);
      end
    end
  end

  // monitor: compare select, response pulse and popped data every cycle
  always @(negedge clk) begin : monitor
    int unsigned e;
    chk("perf_sel", perf_sel, in_win(mem_address) && (mem_read || mem_write));
    chk("perf_resp", perf_resp, exp_q.size() > 0);
    if (perf_resp && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("perf_rdata", perf_rdata, e);
    end
  end

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_bus();
    mem_read = 1'b0;
    mem_write = 1'b0;
  endtask

  logic [15:0] snap_a;
  logic [15:0] snap_b;

  initial begin
    // reset state
    tick(3);
    chk("reset_resp", perf_resp, 1'b0);
    chk("reset_rdata", perf_rdata, 16'h0000);
    rst_n = 1'b1;

    // ten prediction events, then read the prediction counter
    bpredicts_inc = 1'b1;
    tick(10);
    bpredicts_inc = 1'b0;
    mem_address = 16'hFFF0;
    mem_read = 1'b1;
    tick();
    idle_bus();
    chk("bpred_10", perf_rdata, 16'd10);
    chk("bpred_resp", perf_resp, 1'b1);
    tick();
    chk("bpred_resp_once", perf_resp, 1'b0);

    // write stall counter while a stall event arrives: write wins
    mem_address = 16'hFFF4;
    mem_write = 1'b1;
    mem_wdata = 16'h1234;
    stalls_inc = 1'b1;
    tick();
    idle_bus();
    stalls_inc = 1'b0;
    tick();
    mem_read = 1'b1;
    tick();
    idle_bus();
    chk("stall_write_wins", perf_rdata, 16'h1234);
    tick();

    // preload mispredictions near the top, then two events
    mem_address = 16'hFFF2;
    mem_write = 1'b1;
    mem_wdata = 16'hFFFE;
    tick();
    idle_bus();
    tick();
    bmispredicts_inc = 1'b1;
    tick(2);
    bmispredicts_inc = 1'b0;
    mem_read = 1'b1;
    tick();
    idle_bus();
`ifdef PERF_SATURATE_EN
    chk("mispred_top", perf_rdata, 16'hFFFF);
`else
    chk("mispred_top", perf_rdata, 16'h0000);
`endif
    tick();

    // outside the window: no select, no response
    mem_address = 16'hFFE8;
    mem_read = 1'b1;
    tick(3);
    chk("outside_no_resp", perf_resp, 1'b0);
    // odd address inside the window selects the cycle counter
    mem_address = 16'hFFF7;
    tick();
    idle_bus();
    chk("odd_addr_resp", perf_resp, 1'b1);
    tick();

    // held read: responses on N+1 and N+3 only, snapshots two cycles apart
    mem_address = 16'hFFF6;
    mem_read = 1'b1;
    tick();
    chk("held_n1", perf_resp, 1'b1);
    snap_a = perf_rdata;
    tick();
    chk("held_n2", perf_resp, 1'b0);
    tick();
    chk("held_n3", perf_resp, 1'b1);
    snap_b = perf_rdata;
    chk("held_delta", snap_b - snap_a, 16'd2);
    tick();
    idle_bus();
    tick();

    // reset while in RESP, with the request still held across reset
    mem_address = 16'hFFF0;
    mem_read = 1'b1;
    tick();
    chk("pre_rst_resp", perf_resp, 1'b1);
    #1 rst_n = 1'b0;
    #1 chk("rst_drops_resp", perf_resp, 1'b0);
    tick(2);
    rst_n = 1'b1;
    tick();
    chk("reaccept_resp", perf_resp, 1'b1);
    chk("reaccept_zero", perf_rdata, 16'h0000);
    idle_bus();
    tick();

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      bpredicts_inc = 1'($urandom_range(1));
      bmispredicts_inc = 1'($urandom_range(1));
      stalls_inc = 1'($urandom_range(1));
      case ($urandom_range(3))
        0: mem_address = 16'hFFE8;
        1: mem_address = 16'hFFF8 + 16'($urandom_range(7));
        default: mem_address = 16'hFFF0 + 16'($urandom_range(7));
      endcase
      mem_read = ($urandom_range(2) == 0);
      mem_write = ($urandom_range(4) == 0);
      mem_wdata = ($urandom_range(3) == 0) ? 16'hFFFE : 16'($urandom);
      tick();
    end
    idle_bus();
    bpredicts_inc = 1'b0;
    bmispredicts_inc = 1'b0;
    stalls_inc = 1'b0;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/perf_counter_bank.md
# perf_counter_bank

Memory-mapped bank of four 16-bit performance counters that consumes the per-cycle event strobes produced by the hazard-detection stage (correct branch predictions, branch mispredictions, pipeline stall cycles) plus a free-running cycle count. Sits beside the data-memory port: the MEM stage reads or writes the counters with ordinary LDR/STR to a reserved address window, answered by a one-cycle response handshake. The hazard-detection stage and memory arbiter are upstream; the MEM-stage data mux is downstream.

## Interface
- BASE_ADDR, 16'hFFF0: word-aligned base of the 8-byte counter window; bits [2:0] must be 0.
- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- bpredicts_inc  in  1  one correct-prediction event this cycle.
- bmispredicts_inc  in  1  one misprediction event this cycle.
- stalls_inc  in  1  pipeline stalled this cycle.
- mem_address  in  16 (lc3b_word)  data-side address from MEM stage.
- mem_read  in  1  data read request, held until mem_resp.
- mem_write  in  1  data write request, held until mem_resp.
- mem_wdata  in  16  write data.
- perf_sel  out  1  combinational: address in window and (mem_read|mem_write); steers MEM-stage mux away from the cache.
- perf_rdata  out  16  read data, valid while perf_resp high.
- perf_resp  out  1  one-cycle completion pulse.

## Operation
- Window: hit when mem_address[15:3] == BASE_ADDR[15:3]; index = mem_address[2:1]: 0 predictions, 1 mispredictions, 2 stalls, 3 cycles. mem_address[0] ignored.
- Counter increment: one per cycle its strobe is high; cycle counter increments every cycle out of reset.
- Write: counter[index] <= mem_wdata (write 0 to clear). Full word always; no byte enables.
- Read: perf_rdata = counter[index] sampled in the accepting cycle (snapshot, excludes that cycle's increment).
- FSM two states. IDLE: if perf_sel, perform access, go RESP. RESP: perf_resp=1, perf_rdata held, requests ignored, return IDLE unconditionally.
- Simultaneous write and increment on same counter: write wins, that increment is lost.
- mem_read and mem_write both high: treated as write; perf_rdata = 0.
- Stall counter counts the stall cycles caused by its own access (by design).
- Reset mid-transaction: state to IDLE, all counters 0, perf_resp 0; pending request re-accepted after rst_n rises.

## Timing
- Reset values: all counters 16'h0000, perf_rdata 16'h0000, perf_resp 0, state IDLE.
- Latency: request seen in cycle N -> perf_resp high in cycle N+1 only; earliest next acceptance cycle N+2.
- perf_rdata/perf_resp registered; perf_sel purely combinational.
- Write takes effect at the rising edge ending cycle N; increments resume cycle N+1.

## Configuration
- PERF_SATURATE_EN defined: counters stick at 16'hFFFF; further events ignored until written.
- Not defined: counters wrap 16'hFFFF -> 16'h0000.

## Structure
- lc3b_types gains: enum lc3b_perf_idx {PERF_BPRED, PERF_BMISPRED, PERF_STALL, PERF_CYCLE} (2 bits) and localparam PERF_BASE_DEFAULT = 16'hFFF0.
- One sub-module perf_counter: 16-bit register with inc, load, load_data; write-priority and saturation logic live there; instantiated four times.

## Test plan
- Reset, 10 cycles of bpredicts_inc=1, then read BASE+0 -> perf_resp one cycle later, perf_rdata = 16'd10 (not 11 for acceptance cycle count).
- Write 16'h1234 to BASE+4 (stalls) with stalls_inc=1 same cycle -> subsequent read with stalls_inc=0 returns 16'h1234.
- Preload BASE+2 with 16'hFFFE, two bmispredicts_inc pulses, read -> 16'hFFFF with PERF_SATURATE_EN, 16'h0000 without.
- Access 16'hFFE8 (outside window) -> perf_sel=0, perf_resp never asserts; access 16'hFFF7 -> selects cycle counter.
- Held mem_read for 4 cycles at BASE+6 -> perf_resp high exactly cycles N+1 and N+3, not N+2; two snapshots differ by 2.
- Assert rst_n=0 during RESP state -> perf_resp drops immediately, all counters read 0 after release.
